// File: rtl/lcd_bus_timing_ctrl.sv
// HD44780-style character-LCD write strobe generator: latches one byte per iStart
// rising edge, sequences setup/enable/hold on the bus, then waits the execution time.
module lcd_bus_timing_ctrl #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 16,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int EXEC_LONG_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_EXEC,
    S_DONE
  } state_t;

  // Counter reload values: a phase lasts reload+1 cycles, so a zero-length phase becomes one cycle.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC     > 1) ? SETUP_CYC     - 1 : 0);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'((EN_CYC        > 1) ? EN_CYC        - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC      > 1) ? HOLD_CYC      - 1 : 0);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'((EXEC_CYC      > 1) ? EXEC_CYC      - 1 : 0);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'((EXEC_LONG_CYC > 1) ? EXEC_LONG_CYC - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_q, long_d;
  logic             istart_dly_q;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             start_edge;
  logic             phase_end;

  always_comb begin
    start_edge = iStart & ~istart_dly_q;
    phase_end  = (cnt_q == '0);

    state_d = state_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    data_d  = data_q;
    rs_d    = rs_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = iDATA;
          rs_d    = iRS;
          // Clear Display / Return Home (0x01..0x03) need the long execution wait.
          long_d  = ~iRS & (iDATA[7:2] == 6'd0) & (iDATA != 8'd0);
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_d = S_ENABLE;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ENABLE: begin
        if (phase_end) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_d = S_EXEC;
          cnt_d   = long_q ? LONG_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (phase_end) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they are registered yet phase-aligned.
    en_d   = (state_d == S_ENABLE);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      long_q       <= 1'b0;
      istart_dly_q <= 1'b0;
      data_q       <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      long_q       <= long_d;
      istart_dly_q <= iStart;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;
  assign oDone    = done_q;
  assign oBusy    = busy_q;

endmodule

// File: doc/lcd_bus_timing_ctrl.md
Name: lcd_bus_timing_ctrl

Overview:
- Low-level HD44780-style character-LCD bus driver, one stage downstream of the LCD sequencer/LUT stage.
- Accepts one 8-bit command or data byte per start handshake and drives LCD_DATA/LCD_RS/LCD_EN with parameterised setup, enable-width and hold timing.
- Waits a command-dependent execution time before pulsing oDone, so the sequencer can advance.

Parameters:
- SETUP_CYC, 2, cycles RS/DATA stable before LCD_EN rises (40 ns at 50 MHz).
- EN_CYC, 16, cycles LCD_EN held high (320 ns at 50 MHz).
- HOLD_CYC, 2, cycles RS/DATA held after LCD_EN falls.
- EXEC_CYC, 2000, execution wait for normal commands and data writes (40 us at 50 MHz).
- EXEC_LONG_CYC, 82000, execution wait for Clear Display / Return Home (1.64 ms at 50 MHz).
- CNT_W, 17, phase counter width; must hold the largest *_CYC value.

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  reset, asynchronous, active-low
- iDATA  in  8  byte to write (command or character code)
- iRS  in  1  register select: 0 = instruction, 1 = data
- iStart  in  1  start request; a transaction starts on its rising edge
- oDone  out  1  one-cycle completion pulse
- oBusy  out  1  high from start acceptance through the oDone cycle
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  read/write select; constant 0 (write-only)
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select

Behaviour:
- Reset (async): all outputs and internal registers go to 0, state = IDLE, start-edge register = 0. LCD_EN drops immediately, including mid-transaction. No oDone is issued for an aborted transfer.
- Registered outputs: LCD_DATA, LCD_RS, LCD_EN, oDone, oBusy. LCD_RW is tied to 0.
- Start detect: an iStart_d register samples iStart every cycle. A start edge is iStart=1 while iStart_d=0.
- IDLE:
  - A start edge latches iDATA into LCD_DATA and iRS into LCD_RS.
  - The edge also latches the long flag = (iRS==0 && iDATA[7:2]==0 && iDATA!=0), i.e. 0x01, 0x02, 0x03.
  - Go to SETUP; oBusy goes to 1.
- SETUP: LCD_EN=0 for SETUP_CYC cycles, then go to ENABLE.
- ENABLE: LCD_EN=1 for exactly EN_CYC cycles, then go to HOLD.
- HOLD: LCD_EN=0 and bus unchanged for HOLD_CYC cycles, then go to EXEC.
- EXEC: wait EXEC_LONG_CYC cycles if the long flag is set, else EXEC_CYC cycles, then go to DONE.
- DONE: oDone=1 for exactly one cycle, then return to IDLE with oBusy=0. LCD_DATA and LCD_RS keep their last values.
- Latency: with the start edge at cycle S, LCD_EN is high during cycles S+1+SETUP_CYC through S+SETUP_CYC+EN_CYC. oDone is high at cycle S+1+SETUP_CYC+EN_CYC+HOLD_CYC+EXEC.
- A single counter is reloaded at each phase entry. Every phase lasts exactly its parameter value; a value of 0 is treated as 1.
- iDATA/iRS are sampled only at the start edge. Changes on them during a transaction are ignored.
- A start edge in any state other than IDLE (including the DONE cycle) is dropped, not queued.
- iStart held high past oDone does not retrigger. It must return low, then rise again. This matches the sequencer's hold-start-until-done protocol.
- iStart rising in the same cycle reset deasserts: iStart_d is 0 after reset, so the edge is accepted on the first clock with iRST_N high.

Test Plan (override SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=10, EXEC_LONG_CYC=50):
- Data write: iRS=1, iDATA=0x41, pulse iStart at cycle S -> LCD_RS=1 and LCD_DATA=0x41 from S+1; LCD_EN high in cycles S+3..S+6; oDone exactly at S+19; oBusy high S+1..S+19.
- Clear command: iRS=0, iDATA=0x01 -> oDone at S+59. Repeat with 0x02 and 0x03 -> S+59. Repeat with 0x38 and 0x00 -> S+19.
- Held start: iStart held high for 100 cycles -> exactly one transaction and one oDone; none after. Drop and re-raise iStart -> a second transaction.
- Busy collision: second iStart edge with iDATA=0x55 at S+8 -> ignored; LCD_DATA stays 0x41; single oDone at S+19.
- Reset mid-ENABLE: assert iRST_N=0 at S+4 -> LCD_EN, LCD_DATA, LCD_RS, oBusy = 0 asynchronously; no oDone. After release, a new start completes normally.
- Bus stability: throughout SETUP..HOLD, check LCD_DATA/LCD_RS do not change while iDATA toggles every cycle, and LCD_RW stays 0 always.
